// File: rtl/fft_core8_serializer.sv
// fft_core8_serializer: buffers 8-lane FFT output frames (FRM_DEPTH deep)
// and replays them one complex sample per cycle over a valid/ready stream.
//   in : clk, rst, vld_in, fft_din_re, fft_din_im, dout_rdy, ovf_clr
//   out: dout_vld, dout_re, dout_im, dout_idx, dout_last, ovf
module fft_core8_serializer #(
  parameter int FFT_DATA_WD = 10,
  parameter int FRM_DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_in,
  input  logic [8*FFT_DATA_WD-1:0] fft_din_re,
  input  logic [8*FFT_DATA_WD-1:0] fft_din_im,
  input  logic                     dout_rdy,
  output logic                     dout_vld,
  output logic [FFT_DATA_WD-1:0]   dout_re,
  output logic [FFT_DATA_WD-1:0]   dout_im,
  output logic [2:0]               dout_idx,
  output logic                     dout_last,
  input  logic                     ovf_clr,
  output logic                     ovf
);

  localparam int PW = (FRM_DEPTH > 1) ? $clog2(FRM_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FRM_DEPTH);

  typedef logic [FFT_DATA_WD-1:0] smp_t;

  smp_t          re_q [FRM_DEPTH][8];
  smp_t          im_q [FRM_DEPTH][8];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [2:0]    lane_q, lane_d;
  logic          ovf_q, ovf_d;

  logic xfer, pop, push, drop;

  always_comb begin
    xfer = dout_vld & dout_rdy;
    pop  = xfer & (lane_q == 3'd7);
    // a full buffer still takes a frame when its head leaves this cycle
    push = vld_in & ((count_q < DEPTH_C) | pop);
    drop = vld_in & ~push;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lane_d   = lane_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // 3-bit lane wraps 7->0 exactly on the popping transfer
    if (xfer) lane_d = lane_q + 3'd1;

    // a drop wins over a same-cycle clear
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FRM_DEPTH; f++) begin
        for (int k = 0; k < 8; k++) begin
          re_q[f][k] <= '0;
          im_q[f][k] <= '0;
        end
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lane_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        for (int k = 0; k < 8; k++) begin
          re_q[wr_ptr_q][k] <= fft_din_re[k*FFT_DATA_WD +: FFT_DATA_WD];
          im_q[wr_ptr_q][k] <= fft_din_im[k*FFT_DATA_WD +: FFT_DATA_WD];
        end
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dout_vld  = (count_q != '0);
  assign dout_re   = re_q[rd_ptr_q][lane_q];
  assign dout_im   = im_q[rd_ptr_q][lane_q];
  assign dout_idx  = lane_q;
  assign dout_last = dout_vld & (lane_q == 3'd7);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_core8_serializer.sv
// tb_fft_core8_serializer: directed frames, expected samples queued at
// push time and checked by an independent output monitor.
module tb_fft_core8_serializer;

  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           vld_in = 1'b0;
  logic           dout_rdy = 1'b0;
  logic           ovf_clr = 1'b0;
  logic [8*W-1:0] din_re = '0;
  logic [8*W-1:0] din_im = '0;
  logic           dout_vld;
  logic [W-1:0]   dout_re;
  logic [W-1:0]   dout_im;
  logic [2:0]     dout_idx;
  logic           dout_last;
  logic           ovf;

  fft_core8_serializer #(.FFT_DATA_WD(W), .FRM_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in),
    .fft_din_re(din_re), .fft_din_im(din_im),
    .dout_rdy(dout_rdy), .dout_vld(dout_vld),
    .dout_re(dout_re), .dout_im(dout_im),
    .dout_idx(dout_idx), .dout_last(dout_last),
    .ovf_clr(ovf_clr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [2:0]   idx;
    logic         last;
  } smp_t;

  smp_t q[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // monitor: ordering, stall hold, and no bubbles while frames are queued
  logic stall = 1'b0;
  smp_t held;
  always @(negedge clk) begin
    smp_t e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_vld", 32'(dout_vld), 32'd1);
        chk("hold_re", 32'(dout_re), 32'(held.re));
        chk("hold_im", 32'(dout_im), 32'(held.im));
        chk("hold_idx", 32'(dout_idx), 32'(held.idx));
      end
      if (q.size() != 0) chk("no_gap", 32'(dout_vld), 32'd1);
      if (dout_vld && dout_rdy) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(dout_vld), 32'd0);
        end else begin
          e = q.pop_front();
          chk("re", 32'(dout_re), 32'(e.re));
          chk("im", 32'(dout_im), 32'(e.im));
          chk("idx", 32'(dout_idx), 32'(e.idx));
          chk("last", 32'(dout_last), 32'(e.last));
        end
      end
      stall = dout_vld && !dout_rdy;
      held  = '{re: dout_re, im: dout_im, idx: dout_idx, last: dout_last};
    end
  end

  // lane k: re = bre + k, im = bim - k; called at posedge+1
  task automatic send_frame(input logic [W-1:0] bre, input logic [W-1:0] bim,
                            input bit accept, input bit clr);
    logic [W-1:0] r, m;
    for (int k = 0; k < 8; k++) begin
      r = bre + W'(k);
      m = bim - W'(k);
      din_re[k*W +: W] = r;
      din_im[k*W +: W] = m;
    end
    vld_in  = 1'b1;
    ovf_clr = clr;
    @(posedge clk); #1;
    vld_in  = 1'b0;
    ovf_clr = 1'b0;
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        r = bre + W'(k);
        m = bim - W'(k);
        q.push_back('{re: r, im: m, idx: 3'(k), last: (k == 7)});
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    chk("idle_vld", 32'(dout_vld), 32'd0);
  endtask

  bit [3:0] pat;
  int       n;

  initial begin
    // reset state
    #1;
    chk("rst_vld", 32'(dout_vld), 32'd0);
    chk("rst_re", 32'(dout_re), 32'd0);
    chk("rst_idx", 32'(dout_idx), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // reset during traffic with ovf set
    send_frame(10'h040, 10'h100, 1'b1, 1'b0);
    send_frame(10'h050, 10'h110, 1'b1, 1'b0);
    send_frame(10'h060, 10'h120, 1'b0, 1'b0);
    chk("pre_rst_ovf", 32'(ovf), 32'd1);
    dout_rdy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("arst_vld", 32'(dout_vld), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_re", 32'(dout_re), 32'd0);
    chk("arst_im", 32'(dout_im), 32'd0);
    chk("arst_idx", 32'(dout_idx), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_idle", 32'(dout_vld), 32'd0);

    // single frame re=k+1 im=-(k+1)
    send_frame(10'd1, 10'h3FF, 1'b1, 1'b0);
    drain(20);

    // backpressure 1,0,0,1 repeating
    dout_rdy = 1'b0;
    send_frame(10'd1, 10'h3FF, 1'b1, 1'b0);
    pat = 4'b1001;
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      dout_rdy = pat[i % 4];
      @(posedge clk); #1;
    end
    dout_rdy = 1'b1;
    drain(4);

    // back-to-back frames two cycles apart
    send_frame(10'h0A0, 10'h200, 1'b1, 1'b0);
    @(posedge clk); #1;
    send_frame(10'h0B0, 10'h210, 1'b1, 1'b0);
    drain(40);

    // overflow, clear priority, clear
    dout_rdy = 1'b0;
    send_frame(10'h111, 10'h222, 1'b1, 1'b0);
    send_frame(10'h133, 10'h244, 1'b1, 1'b0);
    chk("full_ovf0", 32'(ovf), 32'd0);
    send_frame(10'h155, 10'h266, 1'b0, 1'b0);
    chk("drop_ovf", 32'(ovf), 32'd1);
    send_frame(10'h177, 10'h288, 1'b0, 1'b1);
    chk("clr_vs_drop", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    dout_rdy = 1'b1;
    drain(40);

    // full buffer accepts on the head's idx7 transfer
    dout_rdy = 1'b0;
    send_frame(10'h301, 10'h011, 1'b1, 1'b0);
    send_frame(10'h311, 10'h021, 1'b1, 1'b0);
    dout_rdy = 1'b1;
    n = 0;
    while (dout_idx != 3'd7 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idx7_reached", 32'(dout_idx), 32'd7);
    send_frame(10'h321, 10'h031, 1'b1, 1'b0);
    chk("fullpop_ovf", 32'(ovf), 32'd0);
    drain(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
